// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared widths, opcodes, LFSR mask, FSM states and ALU golden model
package alu_bist_pkg;
  localparam int OPW = 3;
  localparam int DW = 16;
  localparam int RW = 17;
  localparam logic [OPW-1:0] ALU_ADD = 3'd0;
  localparam logic [OPW-1:0] ALU_SUB = 3'd1;
  localparam logic [OPW-1:0] ALU_AND = 3'd2;
  localparam logic [OPW-1:0] ALU_OR = 3'd3;
  localparam logic [OPW-1:0] ALU_XOR = 3'd4;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  function automatic logic [RW-1:0] alu_expect(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OPW-1:0] op);
    return op == ALU_ADD ? {1'b0, a} + {1'b0, b} :
           op == ALU_SUB ? {1'b0, a} - {1'b0, b} :
           op == ALU_AND ? {1'b0, a & b} :
           op == ALU_OR  ? {1'b0, a | b} :
           op == ALU_XOR ? {1'b0, a ^ b} : '0;
  endfunction
endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if: ALU operand/opcode/result bus; master is the stimulus side
interface alu_bist_if;
  import alu_bist_pkg::*;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in2;
  logic [OPW-1:0] alu_op;
  logic [RW-1:0] alu_out;
  modport master (output alu_in1, alu_in2, alu_op, input alu_out);
  modport slave (input alu_in1, alu_in2, alu_op, output alu_out);
endinterface

// File: rtl/alu_bist_lfsr.sv
// alu_bist_lfsr: 32-bit Galois LFSR with seed load and advance enable
module alu_bist_lfsr
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] q
);
  // an all-zero state would lock up, so a zero seed becomes 1
  localparam logic [31:0] INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= INIT;
    else if (load) q <= INIT;
    else if (adv) q <= (q >> 1) ^ (q[0] ? LFSR_MASK : 32'd0);
endmodule

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: LFSR-driven ALU self-test with golden-model checking
// Optional first-fail capture ports enabled by ALU_BIST_FIRST_FAIL_EN.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  alu_bist_if.master       bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
`ifdef ALU_BIST_FIRST_FAIL_EN
  ,
  output logic [DW-1:0]    fail_in1,
  output logic [DW-1:0]    fail_in2,
  output logic [OPW-1:0]   fail_op,
  output logic [RW-1:0]    fail_out,
  output logic             fail_valid
`endif
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, nv, cnt_nxt, err_nxt;
  logic [RW-1:0] expv;
  logic [31:0] lfsr;
  logic acc, mis, last;
  assign acc = state == IDLE && start;
  assign mis = bus.alu_out != expv;
  assign cnt_nxt = cnt + 1'b1;
  assign last = cnt_nxt == nv;
  assign err_nxt = mis && !(&err_count) ? err_count + 1'b1 : err_count;
  assign busy = state != IDLE;
  assign done = state == DONE;
  alu_bist_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (acc),
    .adv  (state == DRIVE),
    .q    (lfsr)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE  ? (start ? (num_vec == '0 ? DONE : DRIVE) : IDLE) :
                state == DRIVE ? CHECK :
                state == CHECK ? (last ? DONE : DRIVE) : IDLE;
  end
  // pass is settled on entry to DONE so it is valid alongside the done pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.alu_in1 <= '0;
      bus.alu_in2 <= '0;
      bus.alu_op <= '0;
      expv <= '0;
      cnt <= '0;
      nv <= '0;
      err_count <= '0;
      pass <= 1'b0;
    end else begin
      if (acc) begin
        nv <= num_vec;
        cnt <= '0;
        err_count <= '0;
        pass <= num_vec == '0;
      end
      if (state == DRIVE) begin
        bus.alu_in1 <= lfsr[15:0];
        bus.alu_in2 <= lfsr[31:16];
        bus.alu_op <= cnt[2:0];
        expv <= alu_expect(lfsr[15:0], lfsr[31:16], cnt[2:0]);
      end
      if (state == CHECK) begin
        err_count <= err_nxt;
        cnt <= cnt_nxt;
        if (last) pass <= err_nxt == '0;
      end
    end
`ifdef ALU_BIST_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {fail_valid, fail_in1, fail_in2, fail_op, fail_out} <= '0;
    else if (acc) {fail_valid, fail_in1, fail_in2, fail_op, fail_out} <= '0;
    else if (state == CHECK && mis && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_in1 <= bus.alu_in1;
      fail_in2 <= bus.alu_in2;
      fail_op <= bus.alu_op;
      fail_out <= bus.alu_out;
    end
`endif
endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb_alu_bist_ctrl: scoreboard bench for alu_bist_ctrl with good, stuck-bit and constant ALUs
module tb_alu_bist_ctrl;
  logic clk, rst_n;
  logic start0, start1, start2;
  logic [15:0] nv0, nv1;
  logic [3:0] nv2;
  logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] err0, err1;
  logic [3:0] err2;
  logic [34:0] q[$];
  int nassert = 0;
  int nfail = 0;
  alu_bist_if b0 ();
  alu_bist_if b1 ();
  alu_bist_if b2 ();
`ifdef ALU_BIST_FIRST_FAIL_EN
  logic [15:0] fi1_0, fi2_0, fi1_1, fi2_1, fi1_2, fi2_2;
  logic [2:0] fop0, fop1, fop2;
  logic [16:0] fout0, fout1, fout2;
  logic fv0, fv1, fv2;
`endif
  function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    case (op)
      3'd0: ref_alu = {1'b0, a} + {1'b0, b};
      3'd1: ref_alu = {1'b0, a} - {1'b0, b};
      3'd2: ref_alu = {1'b0, a & b};
      3'd3: ref_alu = {1'b0, a | b};
      3'd4: ref_alu = {1'b0, a ^ b};
      default: ref_alu = 17'h0;
    endcase
  endfunction
  function automatic logic [31:0] lnext(input logic [31:0] s);
    lnext = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
  assign b0.alu_out = ref_alu(b0.alu_in1, b0.alu_in2, b0.alu_op);
  assign b1.alu_out = ref_alu(b1.alu_in1, b1.alu_in2, b1.alu_op) & 17'h0FFFF;
  assign b2.alu_out = 17'h1FFFF;
  alu_bist_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .num_vec(nv0), .bus(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef ALU_BIST_FIRST_FAIL_EN
    , .fail_in1(fi1_0), .fail_in2(fi2_0), .fail_op(fop0), .fail_out(fout0), .fail_valid(fv0)
`endif
  );
  alu_bist_ctrl #(.SEED(32'h0001_FFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .num_vec(nv1), .bus(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef ALU_BIST_FIRST_FAIL_EN
    , .fail_in1(fi1_1), .fail_in2(fi2_1), .fail_op(fop1), .fail_out(fout1), .fail_valid(fv1)
`endif
  );
  alu_bist_ctrl #(.CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_vec(nv2), .bus(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef ALU_BIST_FIRST_FAIL_EN
    , .fail_in1(fi1_2), .fail_in2(fi2_2), .fail_op(fop2), .fail_out(fout2), .fail_valid(fv2)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run0(input int n, input bit inj);
    logic [31:0] s;
    logic [34:0] prev, v;
    int ops[8];
    bit ok;
    s = 32'hACE1_2024;
    for (int i = 0; i < 8; i++) ops[i] = 0;
    for (int k = 0; k < n; k++) begin
      q.push_back({s[15:0], s[31:16], 3'(k)});
      s = lnext(s);
    end
    prev = {b0.alu_in1, b0.alu_in2, b0.alu_op};
    start0 = 1'b1;
    nv0 = 16'(n);
    @(negedge clk);
    nv0 = 16'hFFFF;
    for (int j = 1; j <= 2 * n + 2; j++) begin
      start0 = inj && j == 4;
      chk("done", 64'(done0), 64'(j == 2 * n + 1));
      chk("busy", 64'(busy0), 64'(j <= 2 * n + 1));
      if (j % 2 == 0 && j <= 2 * n && q.size() != 0) begin
        v = q.pop_front();
        chk("vector", 64'({b0.alu_in1, b0.alu_in2, b0.alu_op}), 64'(v));
        ops[b0.alu_op]++;
      end
      if (j == 2 * n + 1) begin
        chk("pass", 64'(pass0), 64'd1);
        chk("err_count", 64'(err0), 64'd0);
        if (n == 0) chk("alu_hold", 64'({b0.alu_in1, b0.alu_in2, b0.alu_op}), 64'(prev));
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    if (n == 16) begin
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (ops[i] != 2) ok = 1'b0;
      chk("op_cover", 64'(ok), 64'd1);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    {start0, start1, start2} = '0;
    nv0 = '0;
    nv1 = '0;
    nv2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'({b0.alu_in1, b0.alu_in2, b0.alu_op, busy0, done0, pass0, err0}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run0(16, 1'b0);
    run0(0, 1'b0);
    run0(8, 1'b1);
    start1 = 1'b1;
    nv1 = 16'd1;
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      chk("stuck_done", 64'(done1), 64'(j == 3));
      if (j == 2) chk("stuck_vec", 64'({b1.alu_in1, b1.alu_in2, b1.alu_op}), 64'({16'hFFFF, 16'h0001, 3'd0}));
      if (j == 3) begin
        chk("stuck_err", 64'(err1), 64'd1);
        chk("stuck_pass", 64'(pass1), 64'd0);
`ifdef ALU_BIST_FIRST_FAIL_EN
        chk("first_fail", 64'({fv1, fi1_1, fi2_1, fop1, fout1}), 64'({1'b1, 16'hFFFF, 16'h0001, 3'd0, 17'h00000}));
`endif
      end
      if (j == 4) chk("stuck_pass_hold", 64'(pass1), 64'd0);
      @(negedge clk);
    end
    start2 = 1'b1;
    nv2 = 4'd15;
    @(negedge clk);
    start2 = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      chk("sat_done", 64'(done2), 64'(j == 31));
      if (j == 31) begin
        chk("sat_err", 64'(err2), 64'hF);
        chk("sat_pass", 64'(pass2), 64'd0);
      end
      @(negedge clk);
    end
    start0 = 1'b1;
    nv0 = 16'd8;
    @(negedge clk);
    start0 = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      chk("rst_run_done", 64'(done0), 64'd0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({b0.alu_in1, b0.alu_in2, b0.alu_op, busy0, done0, pass0, err0}), 64'd0);
    @(negedge clk);
    chk("no_done_after_rst", 64'(done0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run0(2, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
